// File: rtl/dcache_wb_buffer_pkg.sv
// dcache_wb_buffer_pkg: shared definitions for the dcache victim write-back buffer
package dcache_wb_buffer_pkg;
    localparam int OFFS_W = 5;

    typedef logic [255:0] way_bus_t;

    typedef enum logic [1:0] {WB_IDLE, WB_ISSUE, WB_WAIT} wb_state_e;

    typedef enum logic [2:0] {
        AXI_IDLE, AXI_READ, AXI_READ_END, AXI_WRITE, AXI_WRITE_END
    } axi_state_e;

    // The bridge can take a new cached write only when it is not mid-transfer
    function automatic logic axi_is_idle(input axi_state_e s);
        return s inside {AXI_IDLE, AXI_READ_END, AXI_WRITE_END};
    endfunction
endpackage

// File: rtl/dcache_wb_buffer_if.sv
// dcache_wb_buffer_if: dcache push/lookup and bridge drain signals of the write-back buffer
interface dcache_wb_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              push_valid_i;
    logic [ADDR_W-1:0] push_addr_i;
    logic [LINE_W-1:0] push_data_i;
    logic              push_ready_o;
    logic [ADDR_W-1:0] lkup_addr_i;
    logic              lkup_hit_o;
    logic [LINE_W-1:0] lkup_data_o;
    logic              rd_pri_i;
    logic              axi_idle_i;
    logic              ca_wreq_o;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [LINE_W-1:0] wb_data_o;
    logic              wend_i;
    logic              empty_o;
    logic              full_o;

    modport master (
        output push_valid_i, push_addr_i, push_data_i, lkup_addr_i, rd_pri_i, axi_idle_i, wend_i,
        input  push_ready_o, lkup_hit_o, lkup_data_o, ca_wreq_o, wb_addr_o, wb_data_o, empty_o, full_o
    );

    modport slave (
        input  push_valid_i, push_addr_i, push_data_i, lkup_addr_i, rd_pri_i, axi_idle_i, wend_i,
        output push_ready_o, lkup_hit_o, lkup_data_o, ca_wreq_o, wb_addr_o, wb_data_o, empty_o, full_o
    );
endinterface

// File: rtl/wb_tag_cam.sv
// wb_tag_cam: tag comparators over all entries with newest-match (closest to tail) priority
module wb_tag_cam #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 27
) (
    input  logic [DEPTH-1:0]         vld,
    input  logic [TAG_W-1:0]         tags [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [TAG_W-1:0]         key,
    output logic                     hit,
    output logic [$clog2(DEPTH)-1:0] idx
);
    localparam int PTR_W = $clog2(DEPTH);

    // Valid entries are contiguous from head, so walking oldest to newest lets the last match win
    always_comb begin
        hit = 1'b0;
        idx = head;
        for (int k = 0; k < DEPTH; k++)
            if (vld[head + PTR_W'(k)] && tags[head + PTR_W'(k)] == key) begin
                hit = 1'b1;
                idx = head + PTR_W'(k);
            end
    end
endmodule

// File: rtl/dcache_wb_buffer.sv
// dcache_wb_buffer: victim line FIFO with push coalescing, read-miss forwarding and serial drain
module dcache_wb_buffer
    import dcache_wb_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input logic aclk,
    input logic aresetn,
    dcache_wb_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ADDR_W - OFFS_W;

    wb_state_e         state, state_nx;
    logic [PTR_W-1:0]  head, tail, lk_idx, co_idx;
    logic [CNT_W-1:0]  cnt;
    logic [DEPTH-1:0]  vld, co_vld;
    logic [TAG_W-1:0]  tag  [DEPTH];
    logic [LINE_W-1:0] data [DEPTH];
    logic              full, empty, in_flight, lk_hit, co_hit, append, coalesce, pop;
    logic              unused_offs;

    assign full      = cnt == CNT_W'(DEPTH);
    assign empty     = cnt == '0;
    assign in_flight = state != WB_IDLE;
    assign pop       = state == WB_WAIT && bus.wend_i;
    assign coalesce  = bus.push_valid_i && co_hit;
    assign append    = bus.push_valid_i && !full && !co_hit;
    // The head being drained is never rewritten, keeping wb_data_o stable until the response
    assign co_vld    = in_flight ? vld & ~(DEPTH'(1) << head) : vld;

    wb_tag_cam #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lkup_cam (
        .vld(vld), .tags(tag), .head(head), .key(bus.lkup_addr_i[ADDR_W-1:OFFS_W]),
        .hit(lk_hit), .idx(lk_idx)
    );

    wb_tag_cam #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_push_cam (
        .vld(co_vld), .tags(tag), .head(head), .key(bus.push_addr_i[ADDR_W-1:OFFS_W]),
        .hit(co_hit), .idx(co_idx)
    );

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            state <= WB_IDLE;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            vld   <= '0;
        end else begin
            state <= state_nx;
            if (append) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            cnt <= cnt + CNT_W'(append) - CNT_W'(pop);
            for (int k = 0; k < DEPTH; k++)
                vld[k] <= (vld[k] && !(pop && head == PTR_W'(k))) || (append && tail == PTR_W'(k));
        end

    always_ff @(posedge aclk)
        if (append) begin
            tag[tail]  <= bus.push_addr_i[ADDR_W-1:OFFS_W];
            data[tail] <= bus.push_data_i;
        end else if (coalesce) begin
            data[co_idx] <= bus.push_data_i;
        end

    always_comb begin
        state_nx = state;
        case (state)
            WB_IDLE:  state_nx = (!empty && bus.axi_idle_i && !bus.rd_pri_i) ? WB_ISSUE : WB_IDLE;
            WB_ISSUE: state_nx = WB_WAIT;
            WB_WAIT:  state_nx = bus.wend_i ? WB_IDLE : WB_WAIT;
            default:  state_nx = WB_IDLE;
        endcase
    end

    assign bus.push_ready_o = !full || co_hit;
    assign bus.lkup_hit_o   = lk_hit;
    assign bus.lkup_data_o  = lk_hit ? data[lk_idx] : '0;
    assign bus.ca_wreq_o    = state == WB_ISSUE;
    assign bus.wb_addr_o    = in_flight ? {tag[head], {OFFS_W{1'b0}}} : '0;
    assign bus.wb_data_o    = in_flight ? data[head] : '0;
    assign bus.empty_o      = empty;
    assign bus.full_o       = full;
    assign unused_offs      = ^{bus.push_addr_i[OFFS_W-1:0], bus.lkup_addr_i[OFFS_W-1:0]};
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// tb_dcache_wb_buffer: directed and random stimulus against a queue model of the write-back buffer
module tb_dcache_wb_buffer;
    import dcache_wb_buffer_pkg::*;

    localparam int DEPTH  = 4;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    dcache_wb_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    dcache_wb_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: oldest line at index 0; drain 0 = none, 1 = request cycle, 2 = awaiting response
    logic [ADDR_W-1:0] m_addr [$];
    logic [LINE_W-1:0] m_data [$];
    int m_drain = 0;
    int m_n, m_co;
    bit m_pop;

    logic [LINE_W-1:0] d1, e1, e2, f1;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int newest(input logic [ADDR_W-1:0] a, input bit skip_head);
        newest = -1;
        for (int j = 0; j < m_addr.size(); j++)
            if (m_addr[j][ADDR_W-1:OFFS_W] == a[ADDR_W-1:OFFS_W] && !(skip_head && j == 0)) newest = j;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    initial forever begin
        @(posedge aclk or negedge aresetn);
        if (!aresetn) begin
            m_addr.delete();
            m_data.delete();
            m_drain = 0;
        end else begin
            m_n = m_addr.size();
            m_pop = m_drain == 2 && bus.wend_i;
            m_co = newest(bus.push_addr_i, m_drain != 0);
            if (bus.push_valid_i) begin
                if (m_co >= 0) m_data[m_co] = bus.push_data_i;
                else if (m_n < DEPTH) begin
                    m_addr.push_back({bus.push_addr_i[ADDR_W-1:OFFS_W], 5'b0});
                    m_data.push_back(bus.push_data_i);
                end
            end
            if (m_pop) begin
                void'(m_addr.pop_front());
                void'(m_data.pop_front());
            end
            if (m_drain == 0) m_drain = (m_n > 0 && bus.axi_idle_i && !bus.rd_pri_i) ? 1 : 0;
            else if (m_drain == 1) m_drain = 2;
            else m_drain = bus.wend_i ? 0 : 2;
        end
    end

    always @(negedge aclk) if (aresetn) begin
        int lk, co;
        logic [ADDR_W-1:0] ea;
        logic [LINE_W-1:0] ed;
        #1;
        lk = newest(bus.lkup_addr_i, 1'b0);
        co = newest(bus.push_addr_i, m_drain != 0);
        ea = (m_drain != 0) ? m_addr[0] : '0;
        ed = (m_drain != 0) ? m_data[0] : '0;
        chk("m_empty", bus.empty_o, m_addr.size() == 0);
        chk("m_full", bus.full_o, m_addr.size() == DEPTH);
        chk("m_push_ready", bus.push_ready_o, m_addr.size() < DEPTH || co >= 0);
        chk("m_ca_wreq", bus.ca_wreq_o, m_drain == 1);
        chk("m_wb_addr", bus.wb_addr_o, ea);
        chk("m_wb_data", bus.wb_data_o, ed);
        chk("m_lkup_hit", bus.lkup_hit_o, lk >= 0);
        chk("m_lkup_data", bus.lkup_data_o, lk >= 0 ? m_data[lk] : '0);
    end

    task automatic wait_wreq(input string name);
        int g = 0;
        while (!bus.ca_wreq_o && g < 40) begin
            @(negedge aclk);
            #2;
            g++;
        end
        chk(name, bus.ca_wreq_o, 1'b1);
    endtask

    task automatic drain(input string name);
        int g = 0;
        bus.push_valid_i = 1'b0;
        bus.rd_pri_i = 1'b0;
        bus.axi_idle_i = 1'b1;
        bus.wend_i = 1'b1;
        while (!bus.empty_o && g < 60) begin
            @(negedge aclk);
            #2;
            g++;
        end
        chk(name, bus.empty_o, 1'b1);
        bus.wend_i = 1'b0;
    endtask

    initial begin
        bus.push_valid_i = 1'b0;
        bus.push_addr_i = '0;
        bus.push_data_i = '0;
        bus.lkup_addr_i = '0;
        bus.rd_pri_i = 1'b0;
        bus.axi_idle_i = 1'b0;
        bus.wend_i = 1'b0;
        for (int n = 0; n < 32; n++) d1[8*n +: 8] = 8'(n);
        #12;
        chk("rst_ca_wreq", bus.ca_wreq_o, 1'b0);
        chk("rst_push_ready", bus.push_ready_o, 1'b1);
        chk("rst_lkup_hit", bus.lkup_hit_o, 1'b0);
        chk("rst_empty", bus.empty_o, 1'b1);
        chk("rst_full", bus.full_o, 1'b0);
        chk("rst_wb_addr", bus.wb_addr_o, '0);
        chk("rst_wb_data", bus.wb_data_o, '0);
        @(negedge aclk);
        aresetn = 1'b1;

        // single line: push, issue, forwarding in WAIT, response
        @(negedge aclk);
        bus.push_valid_i = 1'b1;
        bus.push_addr_i = 32'h1000_0020;
        bus.push_data_i = d1;
        bus.axi_idle_i = 1'b1;
        bus.lkup_addr_i = 32'h1000_003C;
        @(negedge aclk);
        bus.push_valid_i = 1'b0;
        #2;
        chk("t1_no_wreq_yet", bus.ca_wreq_o, 1'b0);
        chk("t1_lkup_hit", bus.lkup_hit_o, 1'b1);
        chk("t1_lkup_data", bus.lkup_data_o, d1);
        @(negedge aclk);
        #2;
        chk("t1_wreq", bus.ca_wreq_o, 1'b1);
        chk("t1_wb_addr", bus.wb_addr_o, 32'h1000_0020);
        chk("t1_wb_data", bus.wb_data_o, d1);
        @(negedge aclk);
        #2;
        chk("t1_wreq_one_cycle", bus.ca_wreq_o, 1'b0);
        chk("t1_wait_hit", bus.lkup_hit_o, 1'b1);
        chk("t1_wait_wb_addr", bus.wb_addr_o, 32'h1000_0020);
        bus.lkup_addr_i = 32'h2000_0000;
        #1;
        chk("t1_miss_hit", bus.lkup_hit_o, 1'b0);
        chk("t1_miss_data", bus.lkup_data_o, '0);
        repeat (9) @(negedge aclk);
        bus.wend_i = 1'b1;
        @(negedge aclk);
        bus.wend_i = 1'b0;
        #2;
        chk("t1_empty", bus.empty_o, 1'b1);

        // fill to full, reject a new tag, coalesce into the tail
        bus.axi_idle_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            bus.push_valid_i = 1'b1;
            bus.push_addr_i = 32'h3000_0000 + 32'(i * 32);
            bus.push_data_i = rand_line();
        end
        @(negedge aclk);
        bus.push_valid_i = 1'b0;
        #2;
        chk("t2_full", bus.full_o, 1'b1);
        bus.push_valid_i = 1'b1;
        bus.push_addr_i = 32'h3000_0100;
        #1;
        chk("t2_reject_new", bus.push_ready_o, 1'b0);
        f1 = rand_line();
        bus.push_addr_i = 32'h3000_0064;
        bus.push_data_i = f1;
        #1;
        chk("t2_accept_coalesce", bus.push_ready_o, 1'b1);
        @(negedge aclk);
        bus.push_valid_i = 1'b0;
        #2;
        bus.lkup_addr_i = 32'h3000_0060;
        #1;
        chk("t2_coalesced_data", bus.lkup_data_o, f1);
        chk("t2_still_full", bus.full_o, 1'b1);

        // read-miss priority holds off the drain
        bus.rd_pri_i = 1'b1;
        bus.axi_idle_i = 1'b1;
        repeat (6) begin
            @(negedge aclk);
            #2;
            chk("t5_rd_pri_hold", bus.ca_wreq_o, 1'b0);
        end
        @(negedge aclk);
        bus.rd_pri_i = 1'b0;
        @(negedge aclk);
        #2;
        chk("t5_rd_pri_release", bus.ca_wreq_o, 1'b1);
        chk("t5_wb_addr", bus.wb_addr_o, 32'h3000_0000);
        drain("t5_drain");

        // same tag while the first copy is in flight
        e1 = rand_line();
        e2 = rand_line();
        @(negedge aclk);
        bus.push_valid_i = 1'b1;
        bus.push_addr_i = 32'h4000_0040;
        bus.push_data_i = e1;
        @(negedge aclk);
        bus.push_valid_i = 1'b0;
        #2;
        wait_wreq("t4_first_issue");
        bus.push_valid_i = 1'b1;
        bus.push_data_i = e2;
        #1;
        chk("t4_push_ready", bus.push_ready_o, 1'b1);
        @(negedge aclk);
        bus.push_valid_i = 1'b0;
        #2;
        bus.lkup_addr_i = 32'h4000_0040;
        #1;
        chk("t4_lkup_newest", bus.lkup_data_o, e2);
        chk("t4_inflight_data", bus.wb_data_o, e1);
        @(negedge aclk);
        bus.wend_i = 1'b1;
        @(negedge aclk);
        bus.wend_i = 1'b0;
        #2;
        chk("t4_one_left", bus.empty_o, 1'b0);
        wait_wreq("t4_second_issue");
        chk("t4_second_data", bus.wb_data_o, e2);
        drain("t4_drain");

        // reset during WAIT abandons the line
        @(negedge aclk);
        bus.push_valid_i = 1'b1;
        bus.push_addr_i = 32'h6000_0080;
        bus.push_data_i = rand_line();
        @(negedge aclk);
        bus.push_valid_i = 1'b0;
        #2;
        wait_wreq("t6_issue");
        @(negedge aclk);
        #2;
        bus.lkup_addr_i = 32'h6000_0080;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_empty", bus.empty_o, 1'b1);
        chk("t6_rst_wreq", bus.ca_wreq_o, 1'b0);
        chk("t6_rst_wb_addr", bus.wb_addr_o, '0);
        chk("t6_rst_wb_data", bus.wb_data_o, '0);
        chk("t6_rst_hit", bus.lkup_hit_o, 1'b0);
        chk("t6_rst_ready", bus.push_ready_o, 1'b1);
        @(negedge aclk);
        aresetn = 1'b1;
        bus.wend_i = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            #2;
            chk("t6_wend_ignored_empty", bus.empty_o, 1'b1);
            chk("t6_wend_ignored_wreq", bus.ca_wreq_o, 1'b0);
        end
        bus.wend_i = 1'b0;

        // random traffic over a small tag pool to exercise coalescing and forwarding
        for (int c = 0; c < 3000; c++) begin
            @(negedge aclk);
            bus.push_valid_i = $urandom_range(0, 9) < 4;
            bus.push_addr_i = 32'h5000_0000 | (32'($urandom_range(0, 5)) << 5) | 32'($urandom_range(0, 31));
            bus.push_data_i = rand_line();
            bus.lkup_addr_i = 32'h5000_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
            bus.rd_pri_i = $urandom_range(0, 4) == 0;
            bus.axi_idle_i = axi_is_idle(axi_state_e'($urandom_range(0, 4)));
            bus.wend_i = $urandom_range(0, 2) == 0;
        end
        @(negedge aclk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
